mont_exp_ctrl: RTL
==================

MONT_EXP_CTRL -- requirements
Module: mont_exp_ctrl

Interface
REQ-001 SHALL have parameter E_WIDTH, default 16, giving the exponent width in bits.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  request a new exponentiation; sampled only in IDLE.
REQ-005 SHALL have port in_x  input  1024  base X, plain domain, X < M.
REQ-006 SHALL have port in_e  input  E_WIDTH  exponent E.
REQ-007 SHALL have port in_m  input  1024  odd modulus M.
REQ-008 SHALL have port in_r2  input  1024  R^2 mod M, where R = 2^1024.
REQ-009 SHALL have port in_rmodm  input  1024  R mod M (Montgomery one).
REQ-010 SHALL have port result  output  1024  X^E mod M.
REQ-011 SHALL have port done  output  1  one-cycle pulse when result is valid.
REQ-012 SHALL have port busy  output  1  high from the cycle after start is accepted until the cycle done pulses.
REQ-013 SHALL have port mm_start  output  1  one-cycle start pulse to the external Montgomery multiplier.
REQ-014 SHALL have ports mm_a, mm_b, mm_m  output  1024 each  multiplier operands and modulus.
REQ-015 SHALL have port mm_result  input  1024  multiplier output, a*b*R^-1 mod M.
REQ-016 SHALL have port mm_done  input  1  one-cycle multiplier completion pulse.

Function
REQ-017 SHALL latch in_x, in_e, in_m, in_r2 and in_rmodm on the cycle start is accepted in IDLE; later input changes have no effect on the operation in progress.
REQ-018 SHALL implement states IDLE -> TOMONT -> SQUARE <-> MULT -> FROMMONT -> IDLE, where each non-IDLE state issues one multiplication.
REQ-019 SHALL, in TOMONT, compute Xt = MM(X, R2) and initialise accumulator A = RmodM and bit index i = E_WIDTH-1.
REQ-020 SHALL, in SQUARE, compute A = MM(A, A), then go to MULT.
REQ-021 SHALL, in MULT, always compute T = MM(A, Xt); A = T if E[i] = 1, else A is unchanged (constant time); then i decrements, next state is SQUARE if i was > 0, else FROMMONT.
REQ-022 SHALL, in FROMMONT, compute result = MM(A, 1), register it, pulse done and return to IDLE.
REQ-023 SHALL issue exactly 2*E_WIDTH+2 mm_start pulses per operation, independent of E.
REQ-024 SHALL assert mm_start for exactly one cycle: the cycle after entering each operation state.
REQ-025 SHALL hold mm_a, mm_b and mm_m stable from the mm_start cycle through the mm_done cycle.
REQ-026 SHALL capture mm_result on the cycle mm_done is high, and SHALL ignore mm_done whenever no multiplication is outstanding.
REQ-027 SHALL, for a multiplier with latency L (mm_done L cycles after mm_start), give start (cycle 0) to done in N*(L+1)+1 cycles, where N = 2*E_WIDTH+2.
REQ-028 SHALL ignore start while busy is high; start on the same cycle as done is also ignored.
REQ-029 SHALL hold result at its last value until the next done; done SHALL never be high for two consecutive cycles.
REQ-030 SHALL produce result = 1 mod M for E = 0.

Reset
REQ-031 SHALL, while resetn = 0, drive the state to IDLE, result = 0, done = 0, busy = 0, mm_start = 0 and mm_a = mm_b = mm_m = 0, independent of clk.
REQ-032 SHALL, on resetn asserted mid-operation, abort without a done pulse; a later mm_done from the aborted multiplication SHALL be ignored.

Verification
REQ-033 SHALL check, with a behavioural multiplier (L=3, E_WIDTH=16): X=2, E=5, M=13, correct R2/RmodM -> result=6; done at cycle 137; 34 mm_start pulses.
REQ-034 SHALL check: X=3, E=16'hFFFF, M=7 -> result=6, with the same cycle count as E=5.
REQ-035 SHALL check: X=5, E=0, M=13 -> result=1.
REQ-036 SHALL check: start re-pulsed at cycles 10 and 50 during an operation -> no effect; exactly one done; result unchanged.
REQ-037 SHALL check: resetn low at cycle 40 for 2 cycles, with the model still delivering mm_done -> no done, outputs at reset values; a fresh start then gives a correct result.
REQ-038 SHALL check: the 1024-bit vector with X, E low 16 bits of a random value, and M odd 1024-bit from the generator script, with L=20 -> matches the Python reference.

Source files
------------

// File: rtl/mont_exp_ctrl.sv
// Montgomery-ladder-free left-to-right modular exponentiation sequencer.
// Drives an external Montgomery multiplier; constant-time in the exponent value.
module mont_exp_ctrl #(
  parameter int E_WIDTH = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [1023:0]      in_x,
  input  logic [E_WIDTH-1:0] in_e,
  input  logic [1023:0]      in_m,
  input  logic [1023:0]      in_r2,
  input  logic [1023:0]      in_rmodm,
  output logic [1023:0]      result,
  output logic               done,
  output logic               busy,
  output logic               mm_start,
  output logic [1023:0]      mm_a,
  output logic [1023:0]      mm_b,
  output logic [1023:0]      mm_m,
  input  logic [1023:0]      mm_result,
  input  logic               mm_done
);

  localparam int W  = 1024;
  localparam int IW = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_TOMONT, S_SQUARE, S_MULT, S_FROMMONT
  } state_t;

  typedef struct packed {
    logic [W-1:0]       x;
    logic [W-1:0]       m;
    logic [W-1:0]       r2;
    logic [E_WIDTH-1:0] e;
  } op_t;

  state_t        state, state_nx;
  op_t           ctx;
  logic [W-1:0]  acc;
  logic [W-1:0]  xt;
  logic [IW-1:0] idx;
  logic          pend;
  logic          accept;
  logic          mm_ack;

  // A start landing on the done cycle is dropped even though the FSM is already idle.
  assign accept = (state == S_IDLE) && start && !done;
  // Completions only count while a multiplication is actually in flight.
  assign mm_ack = mm_done && pend;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (accept) state_nx = S_TOMONT;
      S_TOMONT:   if (mm_ack) state_nx = S_SQUARE;
      S_SQUARE:   if (mm_ack) state_nx = S_MULT;
      S_MULT:     if (mm_ack) state_nx = (idx == '0) ? S_FROMMONT : S_SQUARE;
      S_FROMMONT: if (mm_ack) state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  // Operands derive from registers that only change on mm_ack, so they stay
  // stable for the whole multiplication.
  always_comb begin
    mm_a = '0;
    mm_b = '0;
    mm_m = '0;
    busy = (state != S_IDLE);
    case (state)
      S_TOMONT:   begin mm_a = ctx.x; mm_b = ctx.r2;    mm_m = ctx.m; end
      S_SQUARE:   begin mm_a = acc;   mm_b = acc;       mm_m = ctx.m; end
      S_MULT:     begin mm_a = acc;   mm_b = xt;        mm_m = ctx.m; end
      S_FROMMONT: begin mm_a = acc;   mm_b = W'(1);     mm_m = ctx.m; end
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctx      <= '0;
      acc      <= '0;
      xt       <= '0;
      idx      <= '0;
      pend     <= 1'b0;
      mm_start <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
    end else begin
      mm_start <= (state_nx != state) && (state_nx != S_IDLE);
      done     <= 1'b0;
      if (mm_start)    pend <= 1'b1;
      else if (mm_ack) pend <= 1'b0;
      if (accept) begin
        ctx.x  <= in_x;
        ctx.m  <= in_m;
        ctx.r2 <= in_r2;
        ctx.e  <= in_e;
        acc    <= in_rmodm;
        idx    <= IW'(E_WIDTH - 1);
      end
      if (mm_ack) begin
        case (state)
          S_TOMONT: xt  <= mm_result;
          S_SQUARE: acc <= mm_result;
          S_MULT: begin
            // Product is always computed; the exponent bit only selects whether it is kept.
            if (ctx.e[idx]) acc <= mm_result;
            idx <= idx - IW'(1);
          end
          S_FROMMONT: begin
            result <= mm_result;
            done   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
